// File: rtl/instr_fetch_if.sv
// ============================================================================
// Module      : instr_fetch_if
// Description : Memory-request and decode-slot bundle of the fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic [31:0] pc_plus4;

    modport master (
        output imem_req, imem_addr, instr, instr_pc, instr_valid, pc_plus4,
        input  imem_ready, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_pc, instr_valid, pc_plus4,
        output imem_ready, imem_rdata, stall, redirect, redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
// ============================================================================
// Module      : instr_fetch
// Description : PC owner and instruction fetch with one-entry skid and redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic      clk,
    input  wire logic      reset,
    instr_fetch_if.master  bus
);

    localparam logic [31:0] c_reset_pc = RESET_PC & ~32'h3;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FULL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        instr_valid_q, instr_valid_d;

    logic        w_accept;
    logic [31:0] w_redirect_pc;

    assign w_accept      = !instr_valid_q || !bus.stall;
    assign w_redirect_pc = bus.redirect_pc & ~32'h3;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= FETCH;
            pc_q          <= c_reset_pc;
            skid_instr_q  <= '0;
            skid_pc_q     <= '0;
            pend_pc_q     <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            skid_instr_q  <= skid_instr_d;
            skid_pc_q     <= skid_pc_d;
            pend_pc_q     <= pend_pc_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        skid_instr_d  = skid_instr_q;
        skid_pc_d     = skid_pc_q;
        pend_pc_d     = pend_pc_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        // A valid slot that is not stalled is consumed this cycle.
        instr_valid_d = instr_valid_q && bus.stall;

        case (state_q)
            FETCH: begin
                if (bus.redirect) begin
                    instr_valid_d = 1'b0;
                    if (bus.imem_ready) begin
                        pc_d = w_redirect_pc;
                    end else begin
                        pend_pc_d = w_redirect_pc;
                        state_d   = DRAIN;
                    end
                end else if (bus.imem_ready) begin
                    if (w_accept) begin
                        instr_d       = bus.imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                    end else begin
                        skid_instr_d = bus.imem_rdata;
                        skid_pc_d    = pc_q;
                        state_d      = FULL;
                    end
                    pc_d = pc_q + 32'd4;
                end
            end
            FULL: begin
                if (bus.redirect) begin
                    instr_valid_d = 1'b0;
                    pc_d          = w_redirect_pc;
                    state_d       = FETCH;
                end else if (!bus.stall) begin
                    instr_d       = skid_instr_q;
                    instr_pc_d    = skid_pc_q;
                    instr_valid_d = 1'b1;
                    state_d       = FETCH;
                end
            end
            DRAIN: begin
                // The abandoned request must still complete before the new PC goes out.
                instr_valid_d = 1'b0;
                if (bus.redirect) begin
                    pend_pc_d = w_redirect_pc;
                    if (bus.imem_ready) begin
                        pc_d    = w_redirect_pc;
                        state_d = FETCH;
                    end
                end else if (bus.imem_ready) begin
                    pc_d    = pend_pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign bus.imem_req    = !reset && (state_q != FULL);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc_plus4    = instr_pc_q + 32'd4;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module      : tb_instr_fetch
// Description : Scoreboard bench for instr_fetch with a wait-state memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    instr_fetch_if ifc ();

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    exp_t        sb_q[$];
    int          wait_states = 0;
    int          wait_cnt    = 0;
    logic        discard     = 1'b0;
    logic        pend        = 1'b0;
    logic [31:0] pend_addr   = '0;
    logic [31:0] a0;
    logic [31:0] held_pc;
    logic [31:0] held_instr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd7) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Apply one cycle of stimulus plus the memory response, update the scoreboard.
    task automatic drive(input logic stl, input logic rd, input logic [31:0] rpc);
        exp_t e;
        ifc.stall       = stl;
        ifc.redirect    = rd;
        ifc.redirect_pc = rpc;
        if (pend) begin
            check_eq("req_hold", 32'(ifc.imem_req), 32'd1);
            check_eq("addr_hold", ifc.imem_addr, pend_addr);
        end
        if (ifc.instr_valid && !stl && !rd) begin
            check_eq("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check_eq("sb_pc", ifc.instr_pc, e.pc);
                check_eq("sb_instr", ifc.instr, e.word);
                check_eq("sb_pc_plus4", ifc.pc_plus4, e.pc + 32'd4);
            end
        end
        if (rd) sb_q.delete();
        if (!reset && ifc.imem_req && wait_cnt >= wait_states) begin
            ifc.imem_ready = 1'b1;
            ifc.imem_rdata = mem_word(ifc.imem_addr);
            wait_cnt       = 0;
            if (!rd && !discard) begin
                e.pc   = ifc.imem_addr;
                e.word = mem_word(ifc.imem_addr);
                sb_q.push_back(e);
            end
            discard = 1'b0;
            pend    = 1'b0;
        end else begin
            ifc.imem_ready = 1'b0;
            ifc.imem_rdata = 32'hBAD0_BAD0;
            if (!reset && ifc.imem_req) begin
                wait_cnt++;
                pend      = 1'b1;
                pend_addr = ifc.imem_addr;
                if (rd) discard = 1'b1;
            end else begin
                pend = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic stl, input logic rd, input logic [31:0] rpc);
        drive(stl, rd, rpc);
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        ifc.imem_ready  = 1'b0;
        ifc.imem_rdata  = '0;
        ifc.stall       = 1'b0;
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = '0;
        repeat (3) tick();

        check_eq("rst_req", 32'(ifc.imem_req), 32'd0);
        check_eq("rst_valid", 32'(ifc.instr_valid), 32'd0);
        check_eq("rst_instr", ifc.instr, 32'd0);
        check_eq("rst_instr_pc", ifc.instr_pc, 32'd0);
        check_eq("rst_state", 32'(dut.state_q), 32'd0);

        // Startup with zero-wait memory
        reset = 1'b0;
        #1;
        check_eq("start_req", 32'(ifc.imem_req), 32'd1);
        check_eq("start_addr0", ifc.imem_addr, RST_PC);
        check_eq("start_valid0", 32'(ifc.instr_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check_eq("start_addr1", ifc.imem_addr, RST_PC + 32'd4);
        check_eq("start_valid1", 32'(ifc.instr_valid), 32'd1);
        check_eq("start_ipc1", ifc.instr_pc, RST_PC);
        check_eq("start_instr1", ifc.instr, mem_word(RST_PC));
        step(1'b0, 1'b0, 32'd0);
        check_eq("start_addr2", ifc.imem_addr, RST_PC + 32'd8);
        check_eq("start_ipc2", ifc.instr_pc, RST_PC + 32'd4);
        repeat (4) step(1'b0, 1'b0, 32'd0);

        // Three wait states
        wait_states = 3;
        a0 = ifc.imem_addr;
        for (int i = 0; i < 4; i++) begin
            check_eq("ws_addr", ifc.imem_addr, a0);
            step(1'b0, 1'b0, 32'd0);
            if (i < 3) check_eq("ws_valid_low", 32'(ifc.instr_valid), 32'd0);
        end
        check_eq("ws_valid", 32'(ifc.instr_valid), 32'd1);
        check_eq("ws_ipc", ifc.instr_pc, a0);
        check_eq("ws_instr", ifc.instr, mem_word(a0));

        // Stall for four cycles
        wait_states = 0;
        repeat (2) step(1'b0, 1'b0, 32'd0);
        check_eq("st_pre_valid", 32'(ifc.instr_valid), 32'd1);
        held_pc    = ifc.instr_pc;
        held_instr = ifc.instr;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 32'd0);
            check_eq("st_state_full", 32'(dut.state_q), 32'd1);
            check_eq("st_req_low", 32'(ifc.imem_req), 32'd0);
            check_eq("st_ipc_hold", ifc.instr_pc, held_pc);
            check_eq("st_instr_hold", ifc.instr, held_instr);
        end
        step(1'b0, 1'b0, 32'd0);
        check_eq("st_skid_ipc", ifc.instr_pc, held_pc + 32'd4);
        check_eq("st_skid_valid", 32'(ifc.instr_valid), 32'd1);
        check_eq("st_state_fetch", 32'(dut.state_q), 32'd0);
        check_eq("st_resume_addr", ifc.imem_addr, held_pc + 32'd8);
        repeat (2) step(1'b0, 1'b0, 32'd0);

        // Redirect while a two-wait-state request is outstanding
        wait_states = 2;
        a0 = ifc.imem_addr;
        step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_0100);
        check_eq("rd_state_drain", 32'(dut.state_q), 32'd2);
        check_eq("rd_valid0", 32'(ifc.instr_valid), 32'd0);
        check_eq("rd_old_addr", ifc.imem_addr, a0);
        step(1'b0, 1'b0, 32'd0);
        check_eq("rd_state_fetch", 32'(dut.state_q), 32'd0);
        check_eq("rd_new_addr", ifc.imem_addr, 32'h0000_0100);
        for (int i = 0; i < 2; i++) begin
            check_eq("rd_valid_low", 32'(ifc.instr_valid), 32'd0);
            step(1'b0, 1'b0, 32'd0);
        end
        step(1'b0, 1'b0, 32'd0);
        check_eq("rd_tgt_valid", 32'(ifc.instr_valid), 32'd1);
        check_eq("rd_tgt_ipc", ifc.instr_pc, 32'h0000_0100);

        // Redirect coincident with ready while stalled
        wait_states = 0;
        step(1'b0, 1'b0, 32'd0);
        check_eq("rc_pre_valid", 32'(ifc.instr_valid), 32'd1);
        step(1'b1, 1'b1, 32'h0000_0200);
        check_eq("rc_valid0", 32'(ifc.instr_valid), 32'd0);
        check_eq("rc_no_full", 32'(dut.state_q), 32'd0);
        check_eq("rc_addr", ifc.imem_addr, 32'h0000_0200);
        step(1'b0, 1'b0, 32'd0);
        check_eq("rc_tgt_ipc", ifc.instr_pc, 32'h0000_0200);

        // Redirect to an unaligned top-of-memory address, then wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        check_eq("wr_addr", ifc.imem_addr, 32'hFFFF_FFFC);
        check_eq("wr_valid0", 32'(ifc.instr_valid), 32'd0);
        step(1'b0, 1'b0, 32'd0);
        check_eq("wr_addr_wrap", ifc.imem_addr, 32'h0000_0000);
        check_eq("wr_ipc", ifc.instr_pc, 32'hFFFF_FFFC);
        check_eq("wr_pc_plus4", ifc.pc_plus4, 32'h0000_0000);
        step(1'b0, 1'b0, 32'd0);
        check_eq("wr_ipc_wrap", ifc.instr_pc, 32'h0000_0000);
        step(1'b0, 1'b0, 32'd0);

        // Reset asserted in the middle of a wait
        wait_states = 3;
        repeat (2) step(1'b0, 1'b0, 32'd0);
        reset = 1'b1;
        #2;
        check_eq("mr_req", 32'(ifc.imem_req), 32'd0);
        check_eq("mr_valid", 32'(ifc.instr_valid), 32'd0);
        check_eq("mr_state", 32'(dut.state_q), 32'd0);
        sb_q.delete();
        pend           = 1'b0;
        discard        = 1'b0;
        wait_cnt       = 0;
        ifc.imem_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check_eq("mr_restart_req", 32'(ifc.imem_req), 32'd1);
        check_eq("mr_restart_addr", ifc.imem_addr, RST_PC);
        wait_states = 0;
        step(1'b0, 1'b0, 32'd0);
        check_eq("mr_first_ipc", ifc.instr_pc, RST_PC);
        repeat (3) step(1'b0, 1'b0, 32'd0);

        check_eq("sb_final", 32'(sb_q.size()), 32'(ifc.instr_valid));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
